// File: rtl/constants_pkg.sv
// Shared widths and the fetch FSM state type used by the fetch stage and its bench.
package constants_pkg;

  localparam int INSTRUCTION_POINTER_BITS = 8;
  localparam int MEMORY_DATA_BITS         = 8;
  localparam int INSTRUCTION_BITS         = 16;

  // Fetch sequencer states: ISSUE has nothing in flight, WAIT_HI/WAIT_LO
  // are waiting on the high and low byte of the current instruction.
  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } fetch_state_e;

  // Entry width of the instruction queue: {pc, instruction}.
  function automatic int queue_entry_bits(input int addr_bits, input int data_bits);
    return addr_bits + 2 * data_bits;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instruction} entries.
// Depth must be a power of two so the pointers wrap naturally.
module fetch_queue #(
  parameter int QUEUE_DEPTH = 2,
  parameter int ENTRY_BITS  = 24
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push,
  input  logic [ENTRY_BITS-1:0]              push_data,
  input  logic                               pop,
  input  logic                               flush,
  output logic [ENTRY_BITS-1:0]              head,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   count,
  output logic                               empty,
  output logic                               full
);

  localparam int PTR_BITS = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_BITS = $clog2(QUEUE_DEPTH + 1);

  logic [ENTRY_BITS-1:0] entries_q [QUEUE_DEPTH];
  logic [PTR_BITS-1:0]   rd_ptr_q;
  logic [PTR_BITS-1:0]   wr_ptr_q;
  logic [CNT_BITS-1:0]   count_q;
  logic                  do_pop_s;
  logic                  do_push_s;

  assign empty = (count_q == {CNT_BITS{1'b0}});
  assign full  = (count_q == CNT_BITS'(QUEUE_DEPTH));
  assign count = count_q;
  assign head  = entries_q[rd_ptr_q];

  // A pop on an empty queue is ignored; a push is accepted when there is
  // room or when a pop frees the head slot in the same cycle.
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage, pointers and occupancy; flush drops all entries at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= {PTR_BITS{1'b0}};
      wr_ptr_q <= {PTR_BITS{1'b0}};
      count_q  <= {CNT_BITS{1'b0}};
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        entries_q[i] <= {ENTRY_BITS{1'b0}};
      end
    end else if (flush) begin
      rd_ptr_q <= {PTR_BITS{1'b0}};
      wr_ptr_q <= {PTR_BITS{1'b0}};
      count_q  <= {CNT_BITS{1'b0}};
    end else begin
      if (do_push_s) begin
        entries_q[wr_ptr_q] <= push_data;
        wr_ptr_q            <= wr_ptr_q + PTR_BITS'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CNT_BITS'(1);
        2'b01:   count_q <= count_q - CNT_BITS'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads each 16-bit instruction as two byte reads
// (high at pc, low at pc+1), queues {pc, instr} and hands it to decode over
// valid/ready. A redirect flushes everything and restarts at the target.
module fetch_unit
  import constants_pkg::*;
#(
  parameter int ADDR_BITS   = INSTRUCTION_POINTER_BITS,
  parameter int DATA_BITS   = MEMORY_DATA_BITS,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_en,
  output logic [ADDR_BITS-1:0]   mem_address,
  output logic                   mem_read_en,
  input  logic [DATA_BITS-1:0]   mem_rdata,
  input  logic                   redirect_en,
  input  logic [ADDR_BITS-1:0]   redirect_pc,
  output logic [2*DATA_BITS-1:0] instr,
  output logic [ADDR_BITS-1:0]   instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready
);

  localparam int ENTRY_BITS = queue_entry_bits(ADDR_BITS, DATA_BITS);
  localparam int CNT_BITS   = $clog2(QUEUE_DEPTH + 1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_BITS-1:0]  pc_q, pc_d;
  logic [DATA_BITS-1:0]  hi_byte_q, hi_byte_d;
  logic [ADDR_BITS-1:0]  mem_address_q, mem_address_d;
  logic                  mem_read_en_q, mem_read_en_d;

  logic                  push_s;
  logic                  pop_s;
  logic [ENTRY_BITS-1:0] head_s;
  logic [CNT_BITS-1:0]   count_s;
  logic                  empty_s;
  logic                  full_s;
  logic                  room_now_s;
  logic                  room_after_push_s;
  logic [ADDR_BITS-1:0]  pc_plus1_s;
  logic [ADDR_BITS-1:0]  pc_plus2_s;

  assign instr_valid = !empty_s;
  assign pop_s       = instr_valid && instr_ready && !redirect_en;
  assign instr       = instr_valid ? head_s[2*DATA_BITS-1:0] : {(2*DATA_BITS){1'b0}};
  assign instr_pc    = instr_valid ? head_s[ENTRY_BITS-1:2*DATA_BITS] : {ADDR_BITS{1'b0}};
  assign mem_address = mem_address_q;
  assign mem_read_en = mem_read_en_q;

  // (count - pop) < depth, and (count + 1 - pop) < depth for the cycle that
  // also pushes; these keep the queue from ever overflowing.
  assign room_now_s        = !full_s || pop_s;
  assign room_after_push_s = (count_s < CNT_BITS'(QUEUE_DEPTH - 1)) || pop_s;

  assign pc_plus1_s = pc_q + ADDR_BITS'(1);
  assign pc_plus2_s = pc_q + ADDR_BITS'(2);

  fetch_queue #(
    .QUEUE_DEPTH (QUEUE_DEPTH),
    .ENTRY_BITS  (ENTRY_BITS)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data ({pc_q, hi_byte_q, mem_rdata}),
    .pop       (pop_s),
    .flush     (redirect_en),
    .head      (head_s),
    .count     (count_s),
    .empty     (empty_s),
    .full      (full_s)
  );

  // State register plus the registered memory interface and fetch pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ISSUE;
      pc_q          <= {ADDR_BITS{1'b0}};
      hi_byte_q     <= {DATA_BITS{1'b0}};
      mem_address_q <= {ADDR_BITS{1'b0}};
      mem_read_en_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hi_byte_q     <= hi_byte_d;
      mem_address_q <= mem_address_d;
      mem_read_en_q <= mem_read_en_d;
    end
  end

  // Next-state logic; a redirect abandons whatever is in flight.
  always_comb begin
    state_d = state_q;
    if (redirect_en) begin
      state_d = fetch_en ? WAIT_HI : ISSUE;
    end else begin
      case (state_q)
        ISSUE:   state_d = (fetch_en && room_now_s) ? WAIT_HI : ISSUE;
        WAIT_HI: state_d = WAIT_LO;
        WAIT_LO: state_d = (fetch_en && room_after_push_s) ? WAIT_HI : ISSUE;
        default: state_d = ISSUE;
      endcase
    end
  end

  // Output logic: memory requests, byte capture, queue push and pc update.
  always_comb begin
    pc_d          = pc_q;
    hi_byte_d     = hi_byte_q;
    mem_address_d = mem_address_q;
    mem_read_en_d = 1'b0;
    push_s        = 1'b0;
    if (redirect_en) begin
      pc_d = redirect_pc;
      if (fetch_en) begin
        mem_address_d = redirect_pc;
        mem_read_en_d = 1'b1;
      end else begin
        mem_read_en_d = 1'b0;
      end
    end else begin
      case (state_q)
        ISSUE: begin
          if (fetch_en && room_now_s) begin
            mem_address_d = pc_q;
            mem_read_en_d = 1'b1;
          end else begin
            mem_read_en_d = 1'b0;
          end
        end
        WAIT_HI: begin
          hi_byte_d     = mem_rdata;
          mem_address_d = pc_plus1_s;
          mem_read_en_d = 1'b1;
        end
        WAIT_LO: begin
          push_s = 1'b1;
          pc_d   = pc_plus2_s;
          if (fetch_en && room_after_push_s) begin
            mem_address_d = pc_plus2_s;
            mem_read_en_d = 1'b1;
          end else begin
            mem_read_en_d = 1'b0;
          end
        end
        default: begin
          mem_read_en_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed walk through the fetch scenarios followed by
// a randomized run checked against an instruction-stream reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic [7:0]  mem_address;
  logic        mem_read_en;
  logic [7:0]  mem_rdata;
  logic        redirect_en = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  logic [7:0]  ram [256];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Byte RAM: data for the address registered at edge E is sampled at E+1.
  assign mem_rdata = mem_read_en ? ram[mem_address] : 8'h00;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .mem_address (mem_address),
    .mem_read_en (mem_read_en),
    .mem_rdata   (mem_rdata),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_mem(input string tag, input logic en, input logic [7:0] addr);
    check({tag, "_rden"}, {31'd0, mem_read_en}, {31'd0, en});
    if (en) check({tag, "_addr"}, {24'd0, mem_address}, {24'd0, addr});
  endtask

  task automatic expect_head(input string tag, input logic [15:0] ins, input logic [7:0] pc);
    check({tag, "_head"}, {7'd0, instr_valid, instr_pc, instr}, {7'd0, 1'b1, pc, ins});
  endtask

  task automatic expect_empty(input string tag);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
  endtask

  logic [7:0]  exp_pc;
  logic [7:0]  exp_pc1;
  logic        exp_quiet;
  logic        hold_prev;
  logic [15:0] hold_instr;
  logic [7:0]  hold_pc;
  int          pops;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h00] = 8'h1A; ram[8'h01] = 8'h42; ram[8'h02] = 8'hF0; ram[8'h03] = 8'h00;
    ram[8'h10] = 8'h5A; ram[8'h11] = 8'h3C;
    ram[8'hFE] = 8'hA1; ram[8'hFF] = 8'hB2;
    ram[8'h05] = 8'hC3; ram[8'h06] = 8'h07;
    ram[8'h20] = 8'h9E; ram[8'h21] = 8'h11;

    // Reset values
    reset = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
    tick(); tick();
    check("rst_outputs", {6'd0, mem_read_en, mem_address, instr_valid, instr_pc, instr[7:0]}, 32'd0);
    check("rst_instr", {16'd0, instr}, 32'd0);

    // Basic fetch, ready high
    reset = 1'b0;
    tick(); expect_mem("t1_e1", 1'b1, 8'h00); expect_empty("t1_e1");
    tick(); expect_mem("t1_e2", 1'b1, 8'h01); expect_empty("t1_e2");
    tick(); expect_head("t1_e3", 16'h1A42, 8'h00); expect_mem("t1_e3", 1'b1, 8'h02);
    tick(); expect_empty("t1_e4"); expect_mem("t1_e4", 1'b1, 8'h03);
    tick(); expect_head("t1_e5", 16'hF000, 8'h02); expect_mem("t1_e5", 1'b1, 8'h04);

    // Backpressure: queue fills with pc 00 and 02 and fetch stops
    reset = 1'b1; instr_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    expect_head("t2_e3", 16'h1A42, 8'h00);
    tick(); expect_mem("t2_e4", 1'b1, 8'h03);
    tick(); expect_mem("t2_e5", 1'b0, 8'h00); expect_head("t2_e5", 16'h1A42, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick(); expect_mem("t2_stall", 1'b0, 8'h00); expect_head("t2_stall", 16'h1A42, 8'h00);
    end
    instr_ready = 1'b1;
    tick(); expect_head("t2_pop1", 16'hF000, 8'h02); expect_mem("t2_resume", 1'b1, 8'h04);
    tick(); expect_empty("t2_pop2"); expect_mem("t2_lo", 1'b1, 8'h05);

    // Redirect while the low read of pc 04 is outstanding
    redirect_en = 1'b1; redirect_pc = 8'h10;
    tick(); expect_empty("t3_flush"); expect_mem("t3_hi", 1'b1, 8'h10);
    redirect_en = 1'b0;
    tick(); expect_empty("t3_wait"); expect_mem("t3_lo", 1'b1, 8'h11);
    tick(); expect_head("t3_first", 16'h5A3C, 8'h10);

    // Wrap-around from FE
    redirect_en = 1'b1; redirect_pc = 8'hFE;
    tick(); expect_empty("t4_flush"); expect_mem("t4_hi", 1'b1, 8'hFE);
    redirect_en = 1'b0;
    tick(); expect_mem("t4_lo", 1'b1, 8'hFF);
    tick(); expect_head("t4_fe", 16'hA1B2, 8'hFE); expect_mem("t4_wrap", 1'b1, 8'h00);
    tick(); expect_mem("t4_lo2", 1'b1, 8'h01);
    tick(); expect_head("t4_00", 16'h1A42, 8'h00);

    // Odd redirect target
    redirect_en = 1'b1; redirect_pc = 8'h05;
    tick(); expect_mem("t5_hi", 1'b1, 8'h05);
    redirect_en = 1'b0;
    tick(); expect_mem("t5_lo", 1'b1, 8'h06);
    tick(); expect_head("t5_odd", 16'hC307, 8'h05); expect_mem("t5_next", 1'b1, 8'h07);

    // fetch_en dropped mid-fetch: current instruction completes, nothing new
    redirect_en = 1'b1; redirect_pc = 8'h20;
    tick(); expect_mem("t6_hi", 1'b1, 8'h20);
    redirect_en = 1'b0; fetch_en = 1'b0;
    tick(); expect_mem("t6_lo", 1'b1, 8'h21);
    tick(); expect_head("t6_done", 16'h9E11, 8'h20); expect_mem("t6_idle0", 1'b0, 8'h00);
    tick(); expect_mem("t6_idle1", 1'b0, 8'h00);
    tick(); expect_mem("t6_idle2", 1'b0, 8'h00);
    fetch_en = 1'b1;
    tick(); expect_mem("t6_restart", 1'b1, 8'h22);

    // Reset pulse during WAIT_HI
    reset = 1'b1;
    tick();
    check("t6_rst_outputs", {6'd0, mem_read_en, mem_address, instr_valid, instr_pc, instr[7:0]}, 32'd0);
    reset = 1'b0;
    tick(); expect_mem("t6_rst_e1", 1'b1, 8'h00);
    tick(); expect_mem("t6_rst_e2", 1'b1, 8'h01);
    tick(); expect_head("t6_rst_e3", 16'h1A42, 8'h00);

    // Randomized run against an instruction-stream model
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    reset = 1'b1; redirect_en = 1'b0;
    tick();
    reset = 1'b0;
    exp_pc = 8'h00; exp_quiet = 1'b0; hold_prev = 1'b0; pops = 0;
    hold_instr = 16'h0000; hold_pc = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if (exp_quiet) check("rnd_quiet", {31'd0, instr_valid}, 32'd0);
      if (hold_prev) check("rnd_hold", {7'd0, instr_valid, instr_pc, instr}, {7'd0, 1'b1, hold_pc, hold_instr});
      fetch_en    = ($urandom_range(0, 99) < 85);
      instr_ready = ($urandom_range(0, 99) < 70);
      redirect_en = ($urandom_range(0, 99) < 4);
      redirect_pc = 8'($urandom_range(0, 255));
      exp_quiet  = redirect_en;
      hold_prev  = instr_valid && !instr_ready && !redirect_en;
      hold_instr = instr;
      hold_pc    = instr_pc;
      if (redirect_en) begin
        exp_pc = redirect_pc;
      end else if (instr_valid && instr_ready) begin
        exp_pc1 = exp_pc + 8'd1;
        check("rnd_instr", {16'd0, instr}, {16'd0, ram[exp_pc], ram[exp_pc1]});
        check("rnd_pc", {24'd0, instr_pc}, {24'd0, exp_pc});
        exp_pc = exp_pc + 8'd2;
        pops++;
      end
      tick();
    end
    check("rnd_liveness", {31'd0, (pops > 300)}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
